// File: rtl/conv_mac_engine.sv
// conv_mac_engine: multi-lane sequential multiply-accumulate over one
// convolution window (SIZE operand pairs plus a bias), LANES products per
// cycle, signed/unsigned operands, arithmetic output shift and optional ReLU.
// Optional feature macro: CONV_MAC_SAT_EN (clamp the result to OUT_WIDTH and
// flag it on sat); when undefined the result wraps and sat stays 0.
// ACC_WIDTH is expected to be larger than OUT_WIDTH.
module conv_mac_engine #(
  parameter int WIDTH     = 8,
  parameter int OUT_WIDTH = 16,
  parameter int SIZE      = 9,
  parameter int LANES     = 1,
  parameter int ACC_WIDTH = 24,
  parameter int SHIFT     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  signed_mode,
  input  logic                  relu_en,
  input  logic [SIZE*WIDTH-1:0] a,
  input  logic [SIZE*WIDTH-1:0] b,
  input  logic [2*WIDTH-1:0]    c,
  output logic                  busy,
  output logic [OUT_WIDTH-1:0]  y,
  output logic                  done,
  output logic                  sat
);

  localparam int IDX_W = $clog2(SIZE + LANES + 1);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                        state, state_next;
  logic [SIZE*WIDTH-1:0]         a_q, b_q;
  logic                          sgn_q, relu_q;
  logic [IDX_W-1:0]              index;
  logic signed [ACC_WIDTH-1:0]   acc, acc_next, beat_sum;
  logic [ACC_WIDTH-1:0]          c_ext;
  logic [ACC_WIDTH-1:0]          r_val;
  logic signed [WIDTH:0]         ea, eb;
  logic signed [2*WIDTH+1:0]     prod;
  logic                          last_beat;
  logic [OUT_WIDTH-1:0]          y_next;
  logic                          sat_next;
  logic                          unused_hi;

  assign busy      = (state == ACCUM);
  assign last_beat = (int'(index) + LANES >= SIZE);
  assign acc_next  = acc + beat_sum;
  assign c_ext     = signed_mode ? {{(ACC_WIDTH-2*WIDTH){c[2*WIDTH-1]}}, c}
                                 : {{(ACC_WIDTH-2*WIDTH){1'b0}}, c};
  assign unused_hi = ^r_val[ACC_WIDTH-1:OUT_WIDTH];

  // State register: IDLE waits for start, ACCUM runs the beats of one window
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state: accept start only in IDLE, return to IDLE after the last beat
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ACCUM;
      ACCUM:   if (last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sum of this beat's lane products; operands are shifted down each beat so
  // the current elements always sit in the low lanes and padding reads as zero
  always_comb begin
    beat_sum = '0;
    ea       = '0;
    eb       = '0;
    prod     = '0;
    for (int l = 0; l < LANES; l++) begin
      ea       = {sgn_q & a_q[l*WIDTH+WIDTH-1], a_q[l*WIDTH +: WIDTH]};
      eb       = {sgn_q & b_q[l*WIDTH+WIDTH-1], b_q[l*WIDTH +: WIDTH]};
      prod     = ea * eb;
      beat_sum = beat_sum + ACC_WIDTH'(prod);
    end
  end

  // Post-processing of the final accumulator: shift, ReLU, reduce to OUT_WIDTH
  always_comb begin
    if (sgn_q) r_val = acc_next >>> SHIFT;
    else       r_val = acc_next >> SHIFT;
    if (relu_q && sgn_q && r_val[ACC_WIDTH-1]) r_val = '0;
    y_next   = r_val[OUT_WIDTH-1:0];
    sat_next = 1'b0;
`ifdef CONV_MAC_SAT_EN
    if (sgn_q) begin
      if (!(&r_val[ACC_WIDTH-1:OUT_WIDTH-1]) && (|r_val[ACC_WIDTH-1:OUT_WIDTH-1])) begin
        sat_next = 1'b1;
        y_next   = r_val[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                      : {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
    end else begin
      if (|r_val[ACC_WIDTH-1:OUT_WIDTH]) begin
        sat_next = 1'b1;
        y_next   = {OUT_WIDTH{1'b1}};
      end
    end
`endif
  end

  // Datapath: capture a window on start, accumulate per beat, publish result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q    <= '0;
      b_q    <= '0;
      sgn_q  <= 1'b0;
      relu_q <= 1'b0;
      acc    <= '0;
      index  <= '0;
      y      <= '0;
      sat    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          a_q    <= a;
          b_q    <= b;
          sgn_q  <= signed_mode;
          relu_q <= relu_en;
          acc    <= c_ext;
          index  <= '0;
        end
      end else begin
        acc   <= acc_next;
        index <= index + IDX_W'(LANES);
        a_q   <= a_q >> (LANES*WIDTH);
        b_q   <= b_q >> (LANES*WIDTH);
        if (last_beat) begin
          y    <= y_next;
          sat  <= sat_next;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_mac_engine.sv
// tb_conv_mac_engine: five engine configurations driven in parallel with the
// same windows; results are compared against a plain-arithmetic dot product
// model. Honors CONV_MAC_SAT_EN in the model the same way as the design.
module tb_conv_mac_engine;

  localparam int SIZE  = 9;
  localparam int WIDTH = 8;
  localparam int NI    = 5;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  start = 1'b0;
  logic                  signed_mode = 1'b0;
  logic                  relu_en = 1'b0;
  logic [SIZE*WIDTH-1:0] a = '0;
  logic [SIZE*WIDTH-1:0] b = '0;
  logic [2*WIDTH-1:0]    c = '0;
  logic [NI-1:0]         done_v, busy_v, sat_v;
  logic [15:0]           y0, y1, y2, y4;
  logic [7:0]            y3;

  int n_checks = 0;
  int n_fail   = 0;

  int lanes_p [NI] = '{1, 4, 3, 2, 2};
  int ow_p    [NI] = '{16, 16, 16, 8, 16};
  int sh_p    [NI] = '{0, 0, 0, 0, 2};

  always #5 clk = ~clk;

  conv_mac_engine #(.LANES(1)) u0 (.clk(clk), .rst(rst), .start(start),
    .signed_mode(signed_mode), .relu_en(relu_en), .a(a), .b(b), .c(c),
    .busy(busy_v[0]), .y(y0), .done(done_v[0]), .sat(sat_v[0]));
  conv_mac_engine #(.LANES(4)) u1 (.clk(clk), .rst(rst), .start(start),
    .signed_mode(signed_mode), .relu_en(relu_en), .a(a), .b(b), .c(c),
    .busy(busy_v[1]), .y(y1), .done(done_v[1]), .sat(sat_v[1]));
  conv_mac_engine #(.LANES(3)) u2 (.clk(clk), .rst(rst), .start(start),
    .signed_mode(signed_mode), .relu_en(relu_en), .a(a), .b(b), .c(c),
    .busy(busy_v[2]), .y(y2), .done(done_v[2]), .sat(sat_v[2]));
  conv_mac_engine #(.LANES(2), .OUT_WIDTH(8)) u3 (.clk(clk), .rst(rst), .start(start),
    .signed_mode(signed_mode), .relu_en(relu_en), .a(a), .b(b), .c(c),
    .busy(busy_v[3]), .y(y3), .done(done_v[3]), .sat(sat_v[3]));
  conv_mac_engine #(.LANES(2), .SHIFT(2)) u4 (.clk(clk), .rst(rst), .start(start),
    .signed_mode(signed_mode), .relu_en(relu_en), .a(a), .b(b), .c(c),
    .busy(busy_v[4]), .y(y4), .done(done_v[4]), .sat(sat_v[4]));

  function automatic longint getY(input int i);
    case (i)
      0:       return longint'(y0);
      1:       return longint'(y1);
      2:       return longint'(y2);
      3:       return longint'(y3);
      default: return longint'(y4);
    endcase
  endfunction

  function automatic logic [SIZE*WIDTH-1:0] fill(input logic [7:0] v);
    return {SIZE{v}};
  endfunction

  // Reference: dot product plus bias in wide integers, then shift/ReLU/reduce
  function automatic void model(input logic [SIZE*WIDTH-1:0] av, bv, input logic [15:0] cv,
                                input bit sg, rl, input int ow, sh,
                                output longint ye, output longint se);
    longint sum, r, mx, mn;
    logic [7:0] ea, eb;
    sum = sg ? longint'($signed(cv)) : longint'(cv);
    for (int k = 0; k < SIZE; k++) begin
      ea = av[k*WIDTH +: WIDTH];
      eb = bv[k*WIDTH +: WIDTH];
      if (sg) sum += longint'($signed(ea)) * longint'($signed(eb));
      else    sum += longint'(ea) * longint'(eb);
    end
    r = sum >>> sh;
    if (rl && sg && r < 0) r = 0;
    se = 0;
`ifdef CONV_MAC_SAT_EN
    if (sg) begin
      mx = (longint'(1) << (ow-1)) - 1;
      mn = -(longint'(1) << (ow-1));
    end else begin
      mx = (longint'(1) << ow) - 1;
      mn = 0;
    end
    if (r > mx) begin r = mx; se = 1; end
    if (r < mn) begin r = mn; se = 1; end
`else
    mx = 0;
    mn = 0;
`endif
    ye = r & ((longint'(1) << ow) - 1);
  endfunction

  task automatic checkOutput(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // One window on all instances; optionally poke start while they are busy
  task automatic applyStimulus(input logic [SIZE*WIDTH-1:0] av, bv, input logic [15:0] cv,
                               input bit sg, rl, input bit poke);
    int     got_cyc [NI];
    int     npulse  [NI];
    longint got_y   [NI];
    longint got_s   [NI];
    longint ey      [NI];
    longint es      [NI];
    int     bcnt;
    for (int i = 0; i < NI; i++) begin
      model(av, bv, cv, sg, rl, ow_p[i], sh_p[i], ey[i], es[i]);
      got_cyc[i] = -1;
      npulse[i]  = 0;
      got_y[i]   = -1;
      got_s[i]   = -1;
    end
    bcnt = 0;
    @(negedge clk);
    a = av; b = bv; c = cv; signed_mode = sg; relu_en = rl; start = 1'b1;
    for (int cyc = 0; cyc < 25; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        start = 1'b0;
        a = {$urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom};
        c = 16'($urandom);
        signed_mode = ~sg;
        relu_en = ~rl;
      end
      if (poke && cyc == 2) start = 1'b1;
      if (poke && cyc == 3) start = 1'b0;
      if (busy_v[0]) bcnt++;
      for (int i = 0; i < NI; i++) begin
        if (done_v[i]) begin
          npulse[i]++;
          if (got_cyc[i] < 0) begin
            got_cyc[i] = cyc;
            got_y[i]   = getY(i);
            got_s[i]   = longint'(sat_v[i]);
          end
        end
      end
    end
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("latency_u%0d", i), got_cyc[i], (SIZE + lanes_p[i] - 1) / lanes_p[i]);
      checkOutput($sformatf("y_u%0d", i), got_y[i], ey[i]);
      checkOutput($sformatf("sat_u%0d", i), got_s[i], es[i]);
      checkOutput($sformatf("pulses_u%0d", i), npulse[i], 1);
      checkOutput($sformatf("yhold_u%0d", i), getY(i), ey[i]);
    end
    checkOutput("busy_cycles_u0", bcnt, SIZE);
  endtask

  // start held high through done: second window follows BEATS+1 cycles later
  task automatic runBackToBack();
    logic [SIZE*WIDTH-1:0] a1, b1, a2, b2;
    logic [15:0] c1, c2;
    longint e1, e2, s1, s2;
    int     cyc1, cyc2, np;
    longint gy1, gy2;
    a1 = {$urandom, $urandom, $urandom}; b1 = {$urandom, $urandom, $urandom};
    a2 = {$urandom, $urandom, $urandom}; b2 = {$urandom, $urandom, $urandom};
    c1 = 16'($urandom); c2 = 16'($urandom);
    model(a1, b1, c1, 1'b1, 1'b0, 16, 0, e1, s1);
    model(a2, b2, c2, 1'b1, 1'b0, 16, 0, e2, s2);
    cyc1 = -1; cyc2 = -1; np = 0; gy1 = -1; gy2 = -1;
    @(negedge clk);
    a = a1; b = b1; c = c1; signed_mode = 1'b1; relu_en = 1'b0; start = 1'b1;
    for (int cyc = 0; cyc < 32; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin a = a2; b = b2; c = c2; end
      if (cyc == 10) start = 1'b0;
      if (done_v[0]) begin
        np++;
        if (cyc1 < 0) begin cyc1 = cyc; gy1 = getY(0); end
        else if (cyc2 < 0) begin cyc2 = cyc; gy2 = getY(0); end
      end
    end
    checkOutput("b2b_first_latency", cyc1, SIZE);
    checkOutput("b2b_first_y", gy1, e1);
    checkOutput("b2b_gap", cyc2 - cyc1, SIZE + 1);
    checkOutput("b2b_second_y", gy2, e2);
    checkOutput("b2b_pulses", np, 2);
  endtask

  // Reset asserted mid-window: outputs clear and the window never completes
  task automatic runResetAbort();
    int np;
    np = 0;
    @(negedge clk);
    a = fill(8'd2); b = fill(8'd3); c = 16'd5; signed_mode = 1'b0; relu_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_busy", longint'(busy_v), 0);
    checkOutput("rst_done", longint'(done_v), 0);
    checkOutput("rst_sat", longint'(sat_v), 0);
    checkOutput("rst_y0", getY(0), 0);
    checkOutput("rst_y1", getY(1), 0);
    @(negedge clk);
    rst = 1'b1;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(negedge clk);
      if (done_v != '0) np++;
    end
    checkOutput("rst_no_done", np, 0);
  endtask

  initial begin
    logic [SIZE*WIDTH-1:0] ra, rb;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", longint'(busy_v), 0);
    checkOutput("reset_done", longint'(done_v), 0);
    checkOutput("reset_sat", longint'(sat_v), 0);
    checkOutput("reset_y0", getY(0), 0);
    checkOutput("reset_y3", getY(3), 0);
    rst = 1'b1;

    $display("[TB] directed windows");
    applyStimulus(fill(8'd2), fill(8'd3), 16'd5, 1'b0, 1'b0, 1'b0);
    checkOutput("plan_unsigned_y", getY(0), 59);
    applyStimulus(fill(8'hFF), fill(8'd4), 16'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("plan_signed_y", getY(0), 16'hFFDC);
    applyStimulus(fill(8'hFF), fill(8'd4), 16'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("plan_relu_y", getY(0), 0);
    applyStimulus(fill(8'd127), fill(8'd127), 16'd0, 1'b1, 1'b0, 1'b0);
`ifdef CONV_MAC_SAT_EN
    checkOutput("plan_ow8_y", getY(3), 127);
    checkOutput("plan_ow8_sat", longint'(sat_v[3]), 1);
`else
    checkOutput("plan_ow8_y", getY(3), 9);
    checkOutput("plan_ow8_sat", longint'(sat_v[3]), 0);
`endif
    applyStimulus(fill(8'd2), fill(8'd3), 16'd5, 1'b0, 1'b0, 1'b1);
    checkOutput("plan_ignore_y", getY(0), 59);

    $display("[TB] back-to-back and reset abort");
    runBackToBack();
    runResetAbort();
    applyStimulus(fill(8'd2), fill(8'd3), 16'd5, 1'b0, 1'b0, 1'b0);
    checkOutput("plan_after_reset_y", getY(0), 59);

    $display("[TB] random windows");
    for (int n = 0; n < 25; n++) begin
      ra = {$urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom};
      applyStimulus(ra, rb, 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
